pipelined_lzc: RTL and testbench

PIPELINED_LZC -- requirements
Module: pipelined_lzc

---
 rtl/pipelined_lzc.sv | 130 +++++++++++++
 tb/tb_pipelined_lzc.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_lzc.sv
// Two-stage pipelined leading-zero/leading-one counter with normalisation.
// S1 registers the operand and its count; S2 registers the shifted result.
module pipelined_lzc #(
    parameter  int WIDTH     = 24,
    parameter  int TAG_WIDTH = 4,
    localparam int CW        = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_mode,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        out_count,
    output logic                 out_all,
    output logic [WIDTH-1:0]     out_norm,
    output logic [TAG_WIDTH-1:0] out_tag
);

    localparam int LP = $clog2(WIDTH);
    localparam int P  = 1 << LP;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // in_ready depends only on pipeline state and out_ready, never on in_valid.

    // Leaf pairs give a 1-bit count and an all-zero flag; each level merges
    // siblings, taking the upper count unless the upper half is all zero.
    // Merging in place is safe: node n is written only after 2n and 2n+1 are read.
    function automatic logic [LP-1:0] lzc_tree(input logic [P-1:0] x);
        logic [LP-1:0] cnt  [P/2];
        logic          zero [P/2];
        for (int n = 0; n < P / 2; n++) begin
            zero[n]   = ~x[P-1-2*n] & ~x[P-2-2*n];
            cnt[n]    = '0;
            cnt[n][0] = ~x[P-1-2*n];
        end
        for (int l = 1; l < LP; l++) begin
            for (int n = 0; n < (P >> (l + 1)); n++) begin
                if (!zero[2*n]) begin
                    cnt[n] = cnt[2*n];
                end else begin
                    cnt[n]    = cnt[2*n+1];
                    cnt[n][l] = 1'b1;
                end
                zero[n] = zero[2*n] & zero[2*n+1];
            end
        end
        return cnt[0];
    endfunction

    logic [WIDTH-1:0]     w_x;
    logic [P-1:0]         w_padded;
    logic [LP-1:0]        w_tree_cnt;
    logic                 w_all;
    logic [CW-1:0]        w_count;
    logic [WIDTH-1:0]     w_norm;
    logic                 w_s1_load;
    logic                 w_s2_load;

    logic                 r_s1_valid;
    logic [WIDTH-1:0]     r_s1_data;
    logic [TAG_WIDTH-1:0] r_s1_tag;
    logic [CW-1:0]        r_s1_count;
    logic                 r_s1_all;
    logic                 r_s2_valid;
    logic [CW-1:0]        r_out_count;
    logic                 r_out_all;
    logic [WIDTH-1:0]     r_out_norm;
    logic [TAG_WIDTH-1:0] r_out_tag;

    // Padding ones sit below the operand so they never extend a run of zeros.
    always_comb begin
        w_x                    = in_data ^ {WIDTH{in_mode}};
        w_padded               = '1;
        w_padded[P-1 -: WIDTH] = w_x;
    end

    assign w_tree_cnt = lzc_tree(w_padded);
    assign w_all      = ~|w_x;
    assign w_count    = w_all ? CW'(WIDTH) : CW'(w_tree_cnt);
    assign w_norm     = r_s1_data << r_s1_count;

    assign w_s2_load  = !r_s2_valid || out_ready;
    assign w_s1_load  = !r_s1_valid || w_s2_load;
    assign in_ready   = w_s1_load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_s1_tag    <= '0;
            r_s1_count  <= '0;
            r_s1_all    <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_out_count <= '0;
            r_out_all   <= 1'b0;
            r_out_norm  <= '0;
            r_out_tag   <= '0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_data  <= in_data;
                    r_s1_tag   <= in_tag;
                    r_s1_count <= w_count;
                    r_s1_all   <= w_all;
                end
            end
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_count <= r_s1_count;
                    r_out_all   <= r_s1_all;
                    r_out_norm  <= w_norm;
                    r_out_tag   <= r_s1_tag;
                end
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_count = r_out_count;
    assign out_all   = r_out_all;
    assign out_norm  = r_out_norm;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_pipelined_lzc.sv
// Scoreboard bench for pipelined_lzc: directed cases on a 24-bit instance and
// randomized sweeps over several widths against a bit-walking reference model.
module tb_pipelined_lzc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pops_main = 0;

    // Packed result word: {tag, pad, all, count, norm}.
    function automatic logic [95:0] pack(logic [63:0] norm, logic [7:0] cnt, logic all, logic [15:0] tag);
        return {tag, 7'b0, all, cnt, norm};
    endfunction

    // Walk from the MSB while bits equal the mode; shift the raw operand by that run.
    function automatic logic [95:0] ref_model(int w, logic [63:0] d, logic m, logic [15:0] tag);
        int c;
        logic [63:0] mask;
        c    = 0;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        while (c < w && d[w-1-c] == m) c++;
        return pack((d << c) & mask, 8'(c), (c == w), tag);
    endfunction

    // Random operand with a random-length run of the mode bit at the top.
    function automatic logic [63:0] gen_data(int w, logic m);
        logic [63:0] d;
        int k;
        d = {$urandom, $urandom};
        k = $urandom_range(0, w);
        for (int i = 0; i < k; i++) d[w-1-i] = m;
        if (k < w) d[w-1-k] = ~m;
        if (w < 64) d = d & ((64'd1 << w) - 64'd1);
        return d;
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- main 24-bit instance ----------------
    logic        rst;
    logic        in_valid, in_ready, in_mode;
    logic [23:0] in_data;
    logic [3:0]  in_tag;
    logic        out_valid, out_ready, out_all;
    logic [4:0]  out_count;
    logic [23:0] out_norm;
    logic [3:0]  out_tag;
    logic [95:0] q_main[$];

    pipelined_lzc #(.WIDTH(24), .TAG_WIDTH(4)) dut (
        .clk(clk), .reset(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
        .out_all(out_all), .out_norm(out_norm), .out_tag(out_tag)
    );

    function automatic logic [95:0] main_out();
        return pack(64'(out_norm), 8'(out_count), out_all, 16'(out_tag));
    endfunction

    initial forever begin
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            pops_main++;
            if (q_main.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL main_extra: got %h expected no output", main_out());
            end else begin
                chk("main_out", main_out(), q_main.pop_front());
            end
        end
    end

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input logic v, input logic [23:0] d, input logic m, input logic [3:0] t,
                        input logic [95:0] e, output logic acc);
        in_valid = v;
        in_data  = d;
        in_mode  = m;
        in_tag   = t;
        @(negedge clk);
        acc = v && in_ready;
        if (acc) q_main.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // ---------------- random sweep instances ----------------
    for (genvar g = 0; g < 5; g++) begin : g_w
        localparam int W   = (g == 0) ? 2 : (g == 1) ? 5 : (g == 2) ? 24 : (g == 3) ? 53 : 64;
        localparam int GCW = $clog2(W + 1);
        logic           g_rst, vin, rdy, md, ov, ordy, oall, done;
        logic [W-1:0]   din, onorm;
        logic [3:0]     tg, otg;
        logic [GCW-1:0] ocnt;
        logic [95:0]    q[$];

        pipelined_lzc #(.WIDTH(W), .TAG_WIDTH(4)) u_dut (
            .clk(clk), .reset(g_rst),
            .in_valid(vin), .in_ready(rdy), .in_data(din), .in_mode(md), .in_tag(tg),
            .out_valid(ov), .out_ready(ordy), .out_count(ocnt), .out_all(oall),
            .out_norm(onorm), .out_tag(otg)
        );

        initial forever begin
            @(negedge clk);
            if (!g_rst && ov && ordy) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL w%0d_extra: got count %0d expected no output", W, ocnt);
                end else begin
                    chk($sformatf("w%0d_out", W), pack(64'(onorm), 8'(ocnt), oall, 16'(otg)), q.pop_front());
                end
            end
        end

        initial begin
            int sent;
            int cyc;
            logic [63:0] d;
            done  = 1'b0;
            g_rst = 1'b1;
            vin   = 1'b0;
            din   = '0;
            md    = 1'b0;
            tg    = '0;
            ordy  = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            g_rst = 1'b0;
            sent  = 0;
            cyc   = 0;
            while (sent < 200 && cyc < 5000) begin
                vin  = ($urandom_range(0, 3) != 0);
                md   = 1'($urandom_range(0, 1));
                d    = gen_data(W, md);
                din  = d[W-1:0];
                tg   = 4'($urandom_range(0, 15));
                ordy = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (vin && rdy) begin
                    q.push_back(ref_model(W, d, md, 16'(tg)));
                    sent++;
                end
                @(posedge clk);
                #1;
                cyc++;
            end
            chk($sformatf("w%0d_sent", W), 96'(sent), 96'd200);
            vin  = 1'b0;
            ordy = 1'b1;
            cyc  = 0;
            while (q.size() != 0 && cyc < 100) begin
                @(posedge clk);
                cyc++;
            end
            #1;
            chk($sformatf("w%0d_drain", W), 96'(q.size()), 96'd0);
            done = 1'b1;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic        acc;
        int          nacc;
        int          cyc;
        int          p0;
        int          idx;
        logic [63:0] d;
        logic        m;
        logic [3:0]  t;
        logic [23:0] tv_d    [5] = '{24'h000000, 24'h800000, 24'hFFF0FF, 24'hFFFFFF, 24'h0F0000};
        logic        tv_m    [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0]  tv_cnt  [5] = '{8'd24, 8'd0, 8'd12, 8'd24, 8'd4};
        logic        tv_all  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [23:0] tv_norm [5] = '{24'h000000, 24'h800000, 24'h0FF000, 24'h000000, 24'hF00000};
        logic [63:0] bp_d    [5];
        logic        bp_m    [5];

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_tag = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_valid", 96'(out_valid), 96'd0);
        chk("rst_in_ready", 96'(in_ready), 96'd1);
        chk("rst_outputs", main_out(), pack(0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("in_ready_after_rst", 96'(in_ready), 96'd1);

        // Latency: result valid two edges after the operand is presented.
        out_ready = 1'b1;
        step(1'b1, 24'h000100, 1'b0, 4'd3, pack(64'h800000, 8'd15, 1'b0, 16'd3), acc);
        in_valid = 1'b0;
        chk("lat_accept", 96'(acc), 96'd1);
        chk("lat_early", 96'(out_valid), 96'd0);
        @(posedge clk);
        #1;
        chk("lat_valid", 96'(out_valid), 96'd1);
        chk("lat_result", main_out(), pack(64'h800000, 8'd15, 1'b0, 16'd3));

        // Back-to-back operands with mode changes and no bubbles.
        nacc = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, tv_d[i], tv_m[i], 4'(i + 1), pack(64'(tv_norm[i]), tv_cnt[i], tv_all[i], 16'(i + 1)), acc);
            if (acc) nacc++;
        end
        chk("b2b_accepted", 96'(nacc), 96'd5);
        repeat (3) step(1'b0, '0, 1'b0, '0, '0, acc);

        // Backpressure: only two operands fit; outputs hold while stalled.
        for (int i = 0; i < 5; i++) begin
            bp_m[i] = 1'($urandom_range(0, 1));
            bp_d[i] = gen_data(24, bp_m[i]);
        end
        out_ready = 1'b0;
        nacc = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, bp_d[nacc][23:0], bp_m[nacc], 4'(nacc), ref_model(24, bp_d[nacc], bp_m[nacc], 16'(nacc)), acc);
            if (acc) nacc++;
            if (c >= 2) chk("bp_hold", main_out(), q_main[0]);
        end
        chk("bp_accepted", 96'(nacc), 96'd2);
        chk("bp_in_ready", 96'(in_ready), 96'd0);
        chk("bp_valid", 96'(out_valid), 96'd1);
        out_ready = 1'b1;
        p0  = pops_main;
        cyc = 0;
        while (pops_main < p0 + 5 && cyc < 30) begin
            idx = (nacc < 5) ? nacc : 4;
            step(nacc < 5, bp_d[idx][23:0], bp_m[idx], 4'(idx), ref_model(24, bp_d[idx], bp_m[idx], 16'(idx)), acc);
            if (acc) nacc++;
            cyc++;
        end
        chk("bp_release_cycles", 96'(cyc), 96'd5);
        chk("bp_all_accepted", 96'(nacc), 96'd5);

        // Reset with both stages full discards the held results.
        out_ready = 1'b0;
        nacc = 0;
        for (int i = 0; i < 2; i++) begin
            m = 1'($urandom_range(0, 1));
            d = gen_data(24, m);
            step(1'b1, d[23:0], m, 4'hE, ref_model(24, d, m, 16'hE), acc);
            if (acc) nacc++;
        end
        in_valid = 1'b0;
        chk("full_accepted", 96'(nacc), 96'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 96'(out_valid), 96'd0);
        chk("async_rst_outputs", main_out(), pack(0, 0, 0, 0));
        chk("async_rst_in_ready", 96'(in_ready), 96'd1);
        q_main.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_rst_in_ready", 96'(in_ready), 96'd1);
        out_ready = 1'b1;
        step(1'b1, 24'h0000FF, 1'b0, 4'd9, pack(64'hFF0000, 8'd16, 1'b0, 16'd9), acc);
        in_valid = 1'b0;
        chk("post_rst_early", 96'(out_valid), 96'd0);
        @(posedge clk);
        #1;
        chk("post_rst_valid", 96'(out_valid), 96'd1);
        chk("post_rst_result", main_out(), pack(64'hFF0000, 8'd16, 1'b0, 16'd9));
        repeat (4) step(1'b0, '0, 1'b0, '0, '0, acc);

        // Random traffic on the main instance.
        nacc = 0;
        cyc  = 0;
        while (nacc < 300 && cyc < 5000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            m = 1'($urandom_range(0, 1));
            d = gen_data(24, m);
            t = 4'($urandom_range(0, 15));
            step($urandom_range(0, 3) != 0, d[23:0], m, t, ref_model(24, d, m, 16'(t)), acc);
            if (acc) nacc++;
            cyc++;
        end
        chk("main_rand_sent", 96'(nacc), 96'd300);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (q_main.size() != 0 && cyc < 50) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        chk("main_drain", 96'(q_main.size()), 96'd0);

        cyc = 0;
        while (!(g_w[0].done && g_w[1].done && g_w[2].done && g_w[3].done && g_w[4].done) && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        chk("sweeps_done", 96'(g_w[0].done && g_w[1].done && g_w[2].done && g_w[3].done && g_w[4].done), 96'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
